note_display_scanner: RTL and testbench

Parametrised, time-multiplexed musical-note display driver: accepts a stream of notes (C..B plus sharp flag) over a valid/ready handshake, keeps the most recent N_DIGITS notes in a shift buffer, and scans them onto a common-segment multi-digit 7-segment display. It sits between the note source (keyboard/sequencer logic) and the board display pins, and generalises the single-digit note decoder to N digits with storage, scanning, hold and clear.

---
 rtl/note_disp_pkg.sv | 51 +++++
 rtl/note_seg_decoder.sv | 31 +++
 rtl/note_display_scanner.sv | 168 ++++++++++++++++
 tb/tb_note_display_scanner.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_disp_pkg.sv
// ---------------------------------------------------------------------------
// note_disp_pkg
// Shared definitions for the multi-digit note display:
//   - 3-bit note codes (C..B, rest)
//   - 7-segment patterns, bit order abcdefg (seg[6]=a ... seg[0]=g)
//   - slot_t: one buffer entry {valid, sharp, note}
//   - note_to_seg(): note code -> segment pattern (rest -> blank)
// ---------------------------------------------------------------------------
package note_disp_pkg;

    localparam logic [2:0] NOTE_C    = 3'd0;
    localparam logic [2:0] NOTE_D    = 3'd1;
    localparam logic [2:0] NOTE_E    = 3'd2;
    localparam logic [2:0] NOTE_F    = 3'd3;
    localparam logic [2:0] NOTE_G    = 3'd4;
    localparam logic [2:0] NOTE_A    = 3'd5;
    localparam logic [2:0] NOTE_B    = 3'd6;
    localparam logic [2:0] NOTE_REST = 3'd7;

    // D and B use the lower-case glyphs so they are distinguishable from 0 and 8.
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_G     = 7'b1011110;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef struct packed {
        logic       valid;
        logic       sharp;
        logic [2:0] note;
    } slot_t;

    function automatic logic [6:0] note_to_seg(input logic [2:0] note);
        logic [6:0] pattern;
        case (note)
            NOTE_C:  pattern = SEG_C;
            NOTE_D:  pattern = SEG_D;
            NOTE_E:  pattern = SEG_E;
            NOTE_F:  pattern = SEG_F;
            NOTE_G:  pattern = SEG_G;
            NOTE_A:  pattern = SEG_A;
            NOTE_B:  pattern = SEG_B;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/note_seg_decoder.sv
// ---------------------------------------------------------------------------
// note_seg_decoder
// Combinational decode of one buffer slot into segment/decimal-point drive.
// Ports:
//   slot_valid  in   slot holds a note
//   slot_sharp  in   note is sharp
//   slot_note   in   3-bit note code
//   seg         out  segments abcdefg, active-high
//   dp          out  decimal point (sharp marker), active-high
// An empty slot or a rest shows nothing, including no dp.
// ---------------------------------------------------------------------------
module note_seg_decoder
    import note_disp_pkg::*;
(
    input  logic       slot_valid,
    input  logic       slot_sharp,
    input  logic [2:0] slot_note,
    output logic [6:0] seg,
    output logic       dp
);

    always_comb begin
        seg = SEG_BLANK;
        dp  = 1'b0;
        if (slot_valid && (slot_note != NOTE_REST)) begin
            seg = note_to_seg(slot_note);
            dp  = slot_sharp;
        end
    end

endmodule

// File: rtl/note_display_scanner.sv
// ---------------------------------------------------------------------------
// note_display_scanner
// Time-multiplexed N-digit note display. Accepted notes enter slot 0 and push
// older notes towards slot N_DIGITS-1 (the oldest falls off when full). The
// scanner visits one digit per SCAN_DIV cycles; the last cycle of each digit
// period is blanked so the previous digit's segments do not ghost onto the
// next one.
// Parameters:
//   N_DIGITS  digits / buffer depth (2..8)
//   SCAN_DIV  cycles per digit including the blank cycle (>= 2)
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   in_valid  in   note offered
//   in_ready  out  note can be accepted this cycle
//   in_note   in   note code (7 = rest)
//   in_sharp  in   sharp flag
//   hold      in   freeze buffer (blocks input, scanning continues)
//   clear     in   empty buffer (wins over accept and hold)
//   seg       out  segments abcdefg, registered
//   dp        out  decimal point, registered
//   dig_en    out  one-hot digit select, bit 0 = rightmost, registered
//   count     out  number of occupied slots
// ---------------------------------------------------------------------------
module note_display_scanner
    import note_disp_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2:0]                    in_note,
    input  logic                          in_sharp,
    input  logic                          hold,
    input  logic                          clear,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [N_DIGITS-1:0]           dig_en,
    output logic [$clog2(N_DIGITS+1)-1:0] count
);

    localparam int IW = $clog2(N_DIGITS);
    localparam int CW = $clog2(N_DIGITS + 1);
    localparam int PW = $clog2(SCAN_DIV);

    localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(N_DIGITS);

    // ---------------- state ----------------
    slot_t [N_DIGITS-1:0] slots_reg;
    slot_t [N_DIGITS-1:0] slots_next;
    slot_t [N_DIGITS-1:0] slots_shifted;
    logic  [CW-1:0]       count_reg;
    logic  [CW-1:0]       count_next;
    logic  [PW-1:0]       pre_reg;
    logic  [PW-1:0]       pre_next;
    logic  [IW-1:0]       idx_reg;
    logic  [IW-1:0]       idx_next;
    logic  [6:0]          seg_reg;
    logic  [6:0]          seg_next;
    logic                 dp_reg;
    logic                 dp_next;
    logic  [N_DIGITS-1:0] dig_en_reg;
    logic  [N_DIGITS-1:0] dig_en_next;

    logic       accept;
    logic       blank;
    slot_t      shown_slot;
    logic [6:0] dec_seg;
    logic       dec_dp;

    // ---------------- input handshake ----------------
    // Ready depends only on reset/hold/clear so the source never sees a
    // combinational path from its own valid back to ready.
    assign in_ready = rst_n && !hold && !clear;
    assign accept   = in_valid && in_ready;

    // ---------------- shift buffer ----------------
    // Shifted view of the buffer: new note in slot 0, everything else moves up
    // one place; the top slot's old content simply drops out.
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_shift
            if (gi == 0) begin : g_head
                assign slots_shifted[gi] = {1'b1, in_sharp, in_note};
            end else begin : g_body
                assign slots_shifted[gi] = slots_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        slots_next = slots_reg;
        count_next = count_reg;
        if (clear) begin
            slots_next = '0;
            count_next = '0;
        end else if (accept) begin
            slots_next = slots_shifted;
            if (count_reg != COUNT_FULL) begin
                count_next = count_reg + CW'(1);
            end
        end
    end

    // ---------------- scanner ----------------
    assign blank = (pre_reg == PRE_LAST);

    always_comb begin
        pre_next = pre_reg + PW'(1);
        idx_next = idx_reg;
        if (blank) begin
            pre_next = '0;
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
        end
    end

    // idx never exceeds N_DIGITS-1, so the select stays in range even when
    // N_DIGITS is not a power of two.
    assign shown_slot = slots_reg[idx_reg];

    note_seg_decoder u_decoder (
        .slot_valid (shown_slot.valid),
        .slot_sharp (shown_slot.sharp),
        .slot_note  (shown_slot.note),
        .seg        (dec_seg),
        .dp         (dec_dp)
    );

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_dig_en
            assign dig_en_next[gi] = !blank && (idx_reg == IW'(gi));
        end
    endgenerate

    assign seg_next = blank ? SEG_BLANK : dec_seg;
    assign dp_next  = blank ? 1'b0 : dec_dp;

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slots_reg  <= '0;
            count_reg  <= '0;
            pre_reg    <= '0;
            idx_reg    <= '0;
            seg_reg    <= SEG_BLANK;
            dp_reg     <= 1'b0;
            dig_en_reg <= '0;
        end else begin
            slots_reg  <= slots_next;
            count_reg  <= count_next;
            pre_reg    <= pre_next;
            idx_reg    <= idx_next;
            seg_reg    <= seg_next;
            dp_reg     <= dp_next;
            dig_en_reg <= dig_en_next;
        end
    end

    assign seg    = seg_reg;
    assign dp     = dp_reg;
    assign dig_en = dig_en_reg;
    assign count  = count_reg;

endmodule

// File: tb/tb_note_display_scanner.sv
module tb_note_display_scanner;

    localparam int N  = 4;
    localparam int SD = 4;

    localparam logic [6:0] P_C = 7'b1001110;
    localparam logic [6:0] P_D = 7'b0111101;
    localparam logic [6:0] P_E = 7'b1001111;
    localparam logic [6:0] P_F = 7'b1000111;
    localparam logic [6:0] P_G = 7'b1011110;
    localparam logic [6:0] P_A = 7'b1110111;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_note  = 3'd0;
    logic       in_sharp = 1'b0;
    logic       hold     = 1'b0;
    logic       clear    = 1'b0;
    logic       in_ready;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig_en;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    note_display_scanner #(.N_DIGITS(N), .SCAN_DIV(SD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_note  (in_note),
        .in_sharp (in_sharp),
        .hold     (hold),
        .clear    (clear),
        .seg      (seg),
        .dp       (dp),
        .dig_en   (dig_en),
        .count    (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Advance until digit k is selected, bounded; a timeout is a failure.
    task automatic wait_digit(input int k);
        logic [3:0] want;
        bit found;
        want  = 4'b0001 << k;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (dig_en === want) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_digit%0d: dig_en=%b never reached %b", k, dig_en, want);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_seq [8];
        exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0000,
                    4'b0010, 4'b0010, 4'b0010, 4'b0000};
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_note  = 3'd3;
        tick();
        tick();
        checks++;
        if ({dig_en, seg, dp} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs: dig_en=%b seg=%b dp=%b want all 0", dig_en, seg, dp);
        end
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", count);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", in_ready);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %b want 1", in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (dig_en !== exp_seq[i] || seg !== 7'd0) begin
                errors++;
                $display("FAIL scan_seq[%0d]: dig_en=%b seg=%b want dig_en=%b seg=0000000",
                         i, dig_en, seg, exp_seq[i]);
            end
        end
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL scan_count: got %0d want 0", count);
        end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_push_e_sharp();
        in_valid = 1'b1;
        in_note  = 3'd2;
        in_sharp = 1'b1;
        tick();
        in_valid = 1'b0;
        in_sharp = 1'b0;
        checks++;
        if (count !== 3'd1) begin
            errors++;
            $display("FAIL push_e_count: got %0d want 1", count);
        end
        wait_digit(0);
        checks++;
        if (seg !== P_E || dp !== 1'b1) begin
            errors++;
            $display("FAIL push_e_digit0: seg=%b dp=%b want %b dp=1", seg, dp, P_E);
        end
        for (int k = 1; k < N; k++) begin
            wait_digit(k);
            checks++;
            if (seg !== 7'd0 || dp !== 1'b0) begin
                errors++;
                $display("FAIL push_e_digit%0d: seg=%b dp=%b want blank", k, seg, dp);
            end
        end
        $display("test_push_e_sharp done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_shift_saturate();
        logic [2:0] notes [5];
        logic [6:0] exp_seg [4];
        notes   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        exp_seg = '{P_G, P_F, P_E, P_D};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_note  = notes[i];
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL shift_count: got %0d want 4", count);
        end
        for (int k = 0; k < N; k++) begin
            wait_digit(k);
            checks++;
            if (seg !== exp_seg[k] || dp !== 1'b0) begin
                errors++;
                $display("FAIL shift_digit%0d: seg=%b dp=%b want %b dp=0", k, seg, dp, exp_seg[k]);
            end
        end
        $display("test_shift_saturate done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_hold();
        hold     = 1'b1;
        in_valid = 1'b1;
        in_note  = 3'd5;
        in_sharp = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_ready: got %b want 0", in_ready);
        end
        repeat (10) tick();
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL hold_count: got %0d want 4", count);
        end
        wait_digit(0);
        checks++;
        if (seg !== P_G || dp !== 1'b0) begin
            errors++;
            $display("FAIL hold_digit0: seg=%b dp=%b want %b dp=0", seg, dp, P_G);
        end
        wait_digit(3);
        checks++;
        if (seg !== P_D) begin
            errors++;
            $display("FAIL hold_digit3: seg=%b want %b", seg, P_D);
        end
        hold     = 1'b0;
        in_valid = 1'b0;
        in_sharp = 1'b0;
        $display("test_hold done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_clear();
        clear    = 1'b1;
        in_valid = 1'b1;
        in_note  = 3'd5;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready: got %b want 0", in_ready);
        end
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL clear_count: got %0d want 0", count);
        end
        for (int k = 0; k < N; k++) begin
            wait_digit(k);
            checks++;
            if (seg !== 7'd0 || dp !== 1'b0) begin
                errors++;
                $display("FAIL clear_digit%0d: seg=%b dp=%b want blank", k, seg, dp);
            end
        end
        $display("test_clear done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_rest();
        in_valid = 1'b1;
        in_sharp = 1'b1;
        in_note  = 3'd5;
        tick();
        in_note  = 3'd7;
        tick();
        in_valid = 1'b0;
        in_sharp = 1'b0;
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL rest_count: got %0d want 2", count);
        end
        wait_digit(0);
        checks++;
        if (seg !== 7'd0 || dp !== 1'b0) begin
            errors++;
            $display("FAIL rest_digit0: seg=%b dp=%b want blank dp=0", seg, dp);
        end
        wait_digit(1);
        checks++;
        if (seg !== P_A || dp !== 1'b1) begin
            errors++;
            $display("FAIL rest_digit1: seg=%b dp=%b want %b dp=1", seg, dp, P_A);
        end
        $display("test_rest done: checks=%0d errors=%0d", checks, errors);
    endtask

    // Note accepted while its digit is on screen appears on the very next edge.
    task automatic test_back_to_back_latency();
        do_reset();
        tick();
        checks++;
        if (dig_en !== 4'b0001 || seg !== 7'd0) begin
            errors++;
            $display("FAIL first_cycle: dig_en=%b seg=%b want 0001 0000000", dig_en, seg);
        end
        in_valid = 1'b1;
        in_note  = 3'd3;
        tick();
        in_valid = 1'b0;
        checks++;
        if (seg !== 7'd0 || count !== 3'd1) begin
            errors++;
            $display("FAIL accept_edge: seg=%b count=%0d want 0000000 1", seg, count);
        end
        tick();
        checks++;
        if (dig_en !== 4'b0001 || seg !== P_F) begin
            errors++;
            $display("FAIL visible_next: dig_en=%b seg=%b want 0001 %b", dig_en, seg, P_F);
        end
        $display("test_back_to_back_latency done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_mid_frame();
        wait_digit(2);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_note  = 3'd1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({dig_en, seg, dp} !== 12'd0 || count !== 3'd0) begin
            errors++;
            $display("FAIL midreset: dig_en=%b seg=%b dp=%b count=%0d want all 0",
                     dig_en, seg, dp, count);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (dig_en !== 4'b0001 || seg !== 7'd0 || count !== 3'd0) begin
            errors++;
            $display("FAIL midreset_release: dig_en=%b seg=%b count=%0d want 0001 0000000 0",
                     dig_en, seg, count);
        end
        $display("test_reset_mid_frame done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_push_e_sharp();
        test_shift_saturate();
        test_hold();
        test_clear();
        test_rest();
        test_back_to_back_latency();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
